// File: rtl/i2c_master16.sv
// i2c_master16: memory-mapped open-drain I2C byte master (START / 8 bits / ACK / STOP).
// Define I2C_CLOCK_STRETCH_EN to let a slave hold SCL low and freeze the quarter timer.
module i2c_master16 #(
    parameter logic [15:0] PRESCALE_RST = 16'd63
) (
    input  logic        phi0,
    input  logic        res,
    input  logic        cs,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        irq,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        scl_in,
    input  logic        sda_in
);

`ifdef I2C_CLOCK_STRETCH_EN
    localparam logic STRETCH_EN = 1'b1;
`else
    localparam logic STRETCH_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_quarter;
    logic [1:0]  w_nextQuarter;
    logic [2:0]  r_bitCnt;
    logic [2:0]  w_nextBitCnt;
    logic [15:0] r_qcnt;
    logic [15:0] w_nextQcnt;
    logic        r_sclOe;
    logic        r_sdaOe;
    logic        w_nextSclOe;
    logic        w_nextSdaOe;

    logic        r_busy;
    logic        r_done;
    logic        r_ackErr;
    logic        r_stretch;
    logic        r_ie;
    logic        r_cmdStop;
    logic        r_cmdWrite;
    logic        r_cmdRead;
    logic        r_cmdNack;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx;
    logic [15:0] r_prescale;
    logic [15:0] r_dout;

    logic        w_cmdWr;
    logic        w_go;
    logic        w_opWrite;
    logic        w_opRead;
    logic        w_opStop;
    logic        w_opNack;
    logic        w_freeze;
    logic        w_sample;
    logic        w_finish;

    assign w_cmdWr = cs & we & (addr == 2'd1);
    assign w_go    = w_cmdWr & ~r_busy & (|din[3:0]);

    // The launching write moves straight out of IDLE, so its op bits come from din, not the latches.
    assign w_opWrite = w_go ? din[2] : r_cmdWrite;
    assign w_opRead  = w_go ? (din[3] & ~din[2]) : r_cmdRead;
    assign w_opStop  = w_go ? din[1] : r_cmdStop;
    assign w_opNack  = w_go ? din[4] : r_cmdNack;

    assign w_freeze = STRETCH_EN
                    & ((r_state == S_BIT) | (r_state == S_ACK))
                    & ((r_quarter == 2'd1) | (r_quarter == 2'd2))
                    & ~r_sclOe & ~scl_in;

    always_comb begin
        w_nextState   = r_state;
        w_nextQuarter = r_quarter;
        w_nextBitCnt  = r_bitCnt;
        w_nextQcnt    = r_qcnt;
        w_nextSclOe   = r_sclOe;
        w_nextSdaOe   = r_sdaOe;
        w_sample      = 1'b0;
        w_finish      = 1'b0;

        if (r_state == S_IDLE) begin
            if (w_go) begin
                w_nextQuarter = 2'd0;
                w_nextBitCnt  = 3'd0;
                w_nextQcnt    = r_prescale;
                if (din[0]) begin
                    w_nextState = S_START;
                end else if (din[2] | din[3]) begin
                    w_nextState = S_BIT;
                end else begin
                    w_nextState = S_STOP;
                end
            end
        end else if (!w_freeze) begin
            if (r_qcnt != 16'd0) begin
                w_nextQcnt = r_qcnt - 16'd1;
            end else begin
                w_nextQcnt    = r_prescale;
                w_nextQuarter = r_quarter + 2'd1;
                w_sample      = (r_quarter == 2'd2) && ((r_state == S_BIT) || (r_state == S_ACK));
                if (r_quarter == 2'd3) begin
                    case (r_state)
                        S_START: begin
                            if (w_opWrite | w_opRead) begin
                                w_nextState  = S_BIT;
                                w_nextBitCnt = 3'd0;
                            end else if (w_opStop) begin
                                w_nextState = S_STOP;
                            end else begin
                                w_finish = 1'b1;
                            end
                        end
                        S_BIT: begin
                            if (r_bitCnt == 3'd7) begin
                                w_nextState = S_ACK;
                            end else begin
                                w_nextBitCnt = r_bitCnt + 3'd1;
                            end
                        end
                        S_ACK: begin
                            if (w_opStop) begin
                                w_nextState = S_STOP;
                            end else begin
                                w_finish = 1'b1;
                            end
                        end
                        default: w_finish = 1'b1;
                    endcase
                    if (w_finish) begin
                        w_nextState = S_IDLE;
                    end
                end
            end
        end

        // Pin levels follow the state/quarter being entered; IDLE keeps whatever the last phase left.
        case (w_nextState)
            S_START: begin
                case (w_nextQuarter)
                    2'd0: w_nextSdaOe = 1'b0;
                    2'd1: begin w_nextSclOe = 1'b0; w_nextSdaOe = 1'b0; end
                    2'd2: begin w_nextSclOe = 1'b0; w_nextSdaOe = 1'b1; end
                    default: begin w_nextSclOe = 1'b1; w_nextSdaOe = 1'b1; end
                endcase
            end
            S_BIT: begin
                case (w_nextQuarter)
                    2'd0: begin
                        w_nextSclOe = 1'b1;
                        w_nextSdaOe = w_opWrite & ~r_tx[3'd7 - w_nextBitCnt];
                    end
                    2'd1, 2'd2: w_nextSclOe = 1'b0;
                    default: w_nextSclOe = 1'b1;
                endcase
            end
            S_ACK: begin
                case (w_nextQuarter)
                    2'd0: begin
                        w_nextSclOe = 1'b1;
                        w_nextSdaOe = w_opRead & ~w_opNack;
                    end
                    2'd1, 2'd2: w_nextSclOe = 1'b0;
                    default: w_nextSclOe = 1'b1;
                endcase
            end
            S_STOP: begin
                case (w_nextQuarter)
                    2'd0: begin w_nextSclOe = 1'b1; w_nextSdaOe = 1'b1; end
                    2'd1: begin w_nextSclOe = 1'b0; w_nextSdaOe = 1'b1; end
                    default: begin w_nextSclOe = 1'b0; w_nextSdaOe = 1'b0; end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge phi0) begin
        if (res) begin
            r_state   <= S_IDLE;
            r_quarter <= 2'd0;
            r_bitCnt  <= 3'd0;
            r_qcnt    <= 16'd0;
            r_sclOe   <= 1'b0;
            r_sdaOe   <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_quarter <= w_nextQuarter;
            r_bitCnt  <= w_nextBitCnt;
            r_qcnt    <= w_nextQcnt;
            r_sclOe   <= w_nextSclOe;
            r_sdaOe   <= w_nextSdaOe;
        end
    end

    always_ff @(posedge phi0) begin
        if (res) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ackErr   <= 1'b0;
            r_stretch  <= 1'b0;
            r_ie       <= 1'b0;
            r_cmdStop  <= 1'b0;
            r_cmdWrite <= 1'b0;
            r_cmdRead  <= 1'b0;
            r_cmdNack  <= 1'b0;
            r_tx       <= 8'h00;
            r_rx       <= 8'h00;
            r_prescale <= PRESCALE_RST;
            r_dout     <= 16'h0000;
        end else begin
            // Status flags are cleared only by a command written while the engine is idle.
            if (w_cmdWr) begin
                r_ie <= din[5];
                if (!r_busy) begin
                    r_done    <= 1'b0;
                    r_ackErr  <= 1'b0;
                    r_stretch <= 1'b0;
                end
            end
            if (w_go) begin
                r_busy     <= 1'b1;
                r_cmdStop  <= din[1];
                r_cmdWrite <= din[2];
                r_cmdRead  <= din[3] & ~din[2];
                r_cmdNack  <= din[4];
            end
            if (w_finish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_freeze) begin
                r_stretch <= 1'b1;
            end
            if (w_sample) begin
                if (r_state == S_BIT) begin
                    r_rx <= {r_rx[6:0], sda_in};
                end else if (r_cmdWrite) begin
                    r_ackErr <= sda_in;
                end
            end
            if (cs && we && (addr == 2'd0)) begin
                r_tx <= din[7:0];
            end
            if (cs && we && (addr == 2'd2)) begin
                r_prescale <= din;
            end
            if (cs && !we) begin
                case (addr)
                    2'd0:    r_dout <= {8'h00, r_rx};
                    2'd1:    r_dout <= {12'h000, r_stretch, r_done, r_ackErr, r_busy};
                    2'd2:    r_dout <= r_prescale;
                    default: r_dout <= 16'h0000;
                endcase
            end
        end
    end

    assign dout   = r_dout;
    assign irq    = r_done & r_ie;
    assign scl_oe = r_sclOe;
    assign sda_oe = r_sdaOe;

endmodule

// File: doc/i2c_master16.md
# i2c_master16

Memory-mapped I2C master peripheral for the gop16 system. It sits between the 65Org16 CPU data bus and the board-level SDA/SCL pins. The CPU writes a byte and a command; the block generates START, eight data bits, ACK/NACK and STOP on an open-drain bus, then reports status. The top level owns the tristate pads: pin = oe ? 0 : Z, with pull-ups.

## Interface
- `PRESCALE_RST`, default 16'd63: reset value of the PRESCALE register, in phi0 cycles per SCL quarter-period minus one.
- `phi0`  in  1  system clock; all logic is on its rising edge.
- `res`  in  1  synchronous reset, active-high.
- `cs`  in  1  chip select for a CPU access.
- `we`  in  1  1 = write, 0 = read; sampled only when cs=1.
- `addr`  in  2  register select.
- `din`  in  16  CPU write data.
- `dout`  out  16  registered read data.
- `irq`  out  1  high while STATUS.done=1 and CTRL.ie=1.
- `scl_oe`  out  1  1 = pull SCL low.
- `sda_oe`  out  1  1 = pull SDA low.
- `scl_in`  in  1  SCL pin level.
- `sda_in`  in  1  SDA pin level.

## Operation
- Register map, addr:
  - 0 DATA: write loads tx[7:0]. Read returns {8'h00, rx[7:0]}.
  - 1 CMD/STATUS. Write bits: 0 START, 1 STOP, 2 WRITE, 3 READ, 4 NACK (send NACK after a READ), 5 ie.
  - 1 CMD/STATUS. Read returns {12'h0, stretch, done, ack_err, busy}.
  - 2 PRESCALE: read/write, 16 bits.
  - 3: reads 16'h0; writes ignored.
- Any CMD write while busy=0 does two things: it clears done, ack_err and stretch, and it latches ie.
- If that write also sets at least one of bits 0-3, busy goes to 1 and the FSM starts. Otherwise there is no bus activity.
- A CMD write while busy=1 only updates ie; the op bits are dropped.
- If WRITE and READ are both set, WRITE wins.
- DATA or PRESCALE writes while busy=1 take effect immediately. Software must not issue them during a transfer.
- FSM states: IDLE, START, BIT, ACK, STOP.
  - From IDLE, a command goes to START if START is set.
  - Else it goes to BIT if WRITE or READ is set.
  - Else it goes to STOP.
- START: 4 quarters.
  - q0-q1: SCL and SDA released.
  - q2: sda_oe=1.
  - q3: scl_oe=1.
  - Then BIT if WRITE or READ is set, else STOP if STOP is set, else DONE.
- BIT: 8 bits, MSB first. Each bit takes 4 quarters.
  - q0: scl_oe=1; sda_oe = WRITE ? ~tx[7-n] : 0.
  - q1-q2: SCL released.
  - At the last cycle of q2: rx shifts in sda_in.
  - q3: scl_oe=1.
- ACK: same 4-quarter shape as BIT.
  - On WRITE: SDA is released and sda_in is sampled at the end of q2. ack_err = sda_in.
  - On READ: sda_oe = ~NACK.
  - Then STOP if STOP is set, else DONE.
- STOP: 4 quarters.
  - q0: scl_oe=1, sda_oe=1.
  - q1: SCL released.
  - q2-q3: SDA released.
- DONE: a 1-cycle action. busy goes to 0 and done to 1, then the FSM returns to IDLE.
- Without STOP, SCL is left low (scl_oe=1) and SDA stays as driven by ACK. This allows chained commands and repeated START.
- A repeated START from the held-low state begins by releasing SDA in q0 and SCL in q1.

## Timing
- One quarter = PRESCALE+1 phi0 cycles. A 16-bit down-counter reloads at each quarter boundary.
- PRESCALE=0 gives 1-cycle quarters.
- Frame length for START+byte+STOP is 4*(1+8+1+1) quarters = 44*(PRESCALE+1) cycles from the CMD write edge to done=1.
- The CMD write edge makes busy=1 on the next cycle. scl_oe and sda_oe are registered.
- Read: dout loads on the phi0 edge where cs=1 and we=0, and is valid the following cycle.
- Reset values:
  - dout=0, scl_oe=0, sda_oe=0, irq=0.
  - busy=done=ack_err=stretch=0, ie=0, tx=rx=0, PRESCALE=PRESCALE_RST.
  - FSM=IDLE.
- Reset mid-transfer returns everything to reset values on the next edge, which releases both lines at once.

## Configuration
- `I2C_CLOCK_STRETCH_EN` defined:
  - In q1-q2 of BIT and ACK, with scl_oe=0, the quarter counter freezes while scl_in=0.
  - stretch is set to 1 if any freeze occurs.
- Undefined:
  - scl_in is ignored, there are no freezes, and stretch always reads 0.
  - Timing is strictly prescale-based.

## Test plan
- Reset check: assert res for 2 cycles. Reading addr 1 gives 16'h0000, addr 2 gives 16'd63. scl_oe=sda_oe=0.
- Write with ACK:
  - Setup: PRESCALE=3; DATA=16'h00A5; CMD=16'h0027; slave ACKs.
  - SDA levels at each SCL rise: 1,0,1,0,0,1,0,1.
  - done=1 exactly 176 cycles after the CMD write. STATUS=16'h0004. irq=1.
- NACK: same as the write-with-ACK case, but the slave leaves SDA high in ACK. STATUS=16'h0006.
- Read:
  - Setup: CMD=16'h001A (READ|STOP|NACK); slave drives 8'h3C.
  - DATA reads 16'h003C. sda_oe=0 throughout ACK. STOP is generated.
- Busy rule, reset, and stretch:
  - A CMD write while busy causes no extra frame.
  - res asserted in BIT q1 gives scl_oe=sda_oe=0 and busy=0 on the next cycle.
  - With `I2C_CLOCK_STRETCH_EN`, holding scl_in=0 for 20 cycles in bit 3 delays done by 20 cycles and sets stretch=1.
